// File: rtl/show_sequencer.sv
// show_sequencer: steps through a small program of 4-bit decoration opcodes.
// Color opcodes update a static lamp-color register; sound and movement
// opcodes are sent to the shared effect actuator over a valid/ready port.
// After each step the block waits a programmable dwell time.
//
// Optional feature: define SHOW_SEQ_LOOP_EN to make the program wrap from
// the last slot back to slot 0 forever instead of stopping in DONE.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start, stop           single-cycle control pulses
//   load_we/addr/data     program write port (ignored while busy)
//   dwell                 dwell length in cycles minus 1
//   cmd_valid/op/ready    effect command handshake
//   color                 00 green, 01 purple, 10 orange, 11 off
//   slot                  current program slot
//   busy, done            status flags
module show_sequencer #(
  parameter int unsigned NSLOT = 4,
  parameter int unsigned DW    = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic                     load_we,
  input  logic [$clog2(NSLOT)-1:0] load_addr,
  input  logic [3:0]               load_data,
  input  logic [DW-1:0]            dwell,
  output logic                     cmd_valid,
  output logic [3:0]               cmd_op,
  input  logic                     cmd_ready,
  output logic [1:0]               color,
  output logic [$clog2(NSLOT)-1:0] slot,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned SW = $clog2(NSLOT);
  localparam logic [SW-1:0] LastSlot = SW'(NSLOT - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StIssue, StDwell, StDone} state_e;

  state_e          state_q, state_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [1:0]      color_q, color_d;
  logic [3:0]      op_q, op_d;
  logic [DW-1:0]   cnt_q, cnt_d;
  logic            stop_pend_q, stop_pend_d;
  logic            cmd_valid_q, busy_q, done_q;
  logic [3:0]      prog_q [NSLOT];
  logic [3:0]      fetch_op;

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    color_d     = color_q;
    op_d        = op_q;
    cnt_d       = cnt_q;
    stop_pend_d = stop_pend_q;
    fetch_op    = prog_q[slot_q];

    unique case (state_q)
      StIdle, StDone: begin
        // stop wins over a simultaneous start
        if (start && !stop) begin
          slot_d  = '0;
          state_d = StFetch;
        end
      end
      StFetch: begin
        op_d = fetch_op;
        if (stop) begin
          state_d = StIdle;
        end else if (fetch_op[3:2] == 2'b01) begin
          // 0111 is a no-op within the color class
          if (fetch_op[1:0] != 2'b11) color_d = fetch_op[1:0];
          cnt_d   = dwell;
          state_d = StDwell;
        end else if (fetch_op[3] && (fetch_op[1:0] != 2'b11)) begin
          stop_pend_d = 1'b0;
          state_d     = StIssue;
        end else if (fetch_op == 4'b0001) begin
          color_d = 2'b11;
          slot_d  = '0;
          state_d = StIdle;
        end else begin
          cnt_d   = dwell;
          state_d = StDwell;
        end
      end
      StIssue: begin
        // A stop here only takes effect once the pending command is accepted.
        if (stop) stop_pend_d = 1'b1;
        if (cmd_valid_q && cmd_ready) begin
          stop_pend_d = 1'b0;
          if (stop || stop_pend_q) begin
            state_d = StIdle;
          end else begin
            cnt_d   = dwell;
            state_d = StDwell;
          end
        end
      end
      StDwell: begin
        if (stop) begin
          state_d = StIdle;
        end else if (cnt_q != '0) begin
          cnt_d = cnt_q - DW'(1);
        end else if (slot_q != LastSlot) begin
          slot_d  = slot_q + SW'(1);
          state_d = StFetch;
        end else begin
`ifdef SHOW_SEQ_LOOP_EN
          slot_d  = '0;
          state_d = StFetch;
`else
          state_d = StDone;
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      slot_q      <= '0;
      color_q     <= 2'b11;
      op_q        <= '0;
      cnt_q       <= '0;
      stop_pend_q <= 1'b0;
      cmd_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      prog_q      <= '{default: '0};
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      color_q     <= color_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      stop_pend_q <= stop_pend_d;
      // Status flags are registered from the next state so they line up
      // with the state register.
      cmd_valid_q <= (state_d == StIssue);
      busy_q      <= (state_d == StFetch) || (state_d == StIssue) || (state_d == StDwell);
      done_q      <= (state_d == StDone);
      if (load_we && !busy_q) prog_q[load_addr] <= load_data;
    end
  end

  assign cmd_valid = cmd_valid_q;
  assign cmd_op    = op_q;
  assign color     = color_q;
  assign slot      = slot_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule
